// File: rtl/sym_conv2d_param.sv
// Parametrised KxK symmetric 2D convolution: column fold, row fold, multiply, registered
// adder tree, then round/saturate. Coefficients load through a shadow bank and a safe commit.
module sym_conv2d_param #(
   parameter int K     = 11,
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int OW    = 18,
   parameter int SHIFT = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [K*K*DW-1:0]                      din,
   input  logic                                   coef_we,
   input  logic [$clog2(((K+1)/2)*((K+1)/2))-1:0] coef_addr,
   input  logic [CW-1:0]                          coef_wdata,
   input  logic                                   coef_commit,
   output logic [OW-1:0]                          dout,
   output logic                                   out_valid,
   output logic                                   sat
);

   localparam int HK  = (K + 1) / 2;
   localparam int NP  = HK * HK;
   localparam int AB  = $clog2(NP);
   localparam int AL  = $clog2(NP);
   localparam int N2  = 1 << AL;
   localparam int AW  = DW + CW + 2 + AL;
   localparam int LAT = 3 + AL + 1;
   localparam int XW  = (AW + 1 > OW) ? AW + 1 : OW + 1;
   localparam logic [XW-1:0] OMAX = XW'({OW{1'b1}});

   typedef enum logic {CS_RUN, CS_PEND} cstate_t;

   cstate_t       state, state_n;
   logic          copy;
   logic          accept;
   logic [LAT:1]  vld;
   logic [CW-1:0] shadow [NP];
   logic [CW-1:0] active [NP];
   logic [DW:0]   a [K][HK];
   logic [DW+1:0] b [HK][HK];
   logic [AW-1:0] sum;
   logic [XW-1:0] rounded;
   logic          clip;

   // Commit handshake: hold off new windows until every in-flight window has left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CS_RUN;
      else     state <= state_n;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_n = state;
      copy    = 1'b0;
      case (state)
         CS_RUN:  if (coef_commit) state_n = CS_PEND;
         CS_PEND: if (!(|vld)) begin
            copy    = 1'b1;
            state_n = CS_RUN;
         end
         default: state_n = CS_RUN;
      endcase
   end

   assign in_ready = (state == CS_RUN);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld <= '0;
      else     vld <= {vld[LAT-1:1], accept};
   end

   assign out_valid = vld[LAT];

   // NOTE: both banks must read as zero after reset, so this small memory is reset explicitly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NP; n++) begin
            shadow[n] <= '0;
            active[n] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make the copy see shadow before a same-cycle write.
         if (copy)
            for (int n = 0; n < NP; n++) active[n] <= shadow[n];
         if (coef_we && ({1'b0, coef_addr} < (AB+1)'(NP)))
            shadow[coef_addr] <= coef_wdata;
      end
   end

   // NOTE: datapath registers carry no reset; the valid chain alone qualifies their contents.
   always_ff @(posedge clk) begin
      for (int r = 0; r < K; r++) begin
         for (int j = 0; j < HK - 1; j++)
            a[r][j] <= (DW+1)'(din[(r*K + j)*DW +: DW]) + (DW+1)'(din[(r*K + K-1-j)*DW +: DW]);
         a[r][HK-1] <= (DW+1)'(din[(r*K + HK-1)*DW +: DW]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < HK - 1; i++)
         for (int j = 0; j < HK; j++)
            b[i][j] <= (DW+2)'(a[i][j]) + (DW+2)'(a[K-1-i][j]);
      for (int j = 0; j < HK; j++)
         b[HK-1][j] <= (DW+2)'(a[HK-1][j]);
   end

   // Level 0 holds the products (padded with zeros to a power of two); each level halves.
   for (genvar l = 0; l <= AL; l++) begin : g_lvl
      logic [AW-1:0] s [N2 >> l];
      if (l == 0) begin : g_mul
         always_ff @(posedge clk) begin
            for (int n = 0; n < NP; n++)
               s[n] <= AW'(b[n / HK][n % HK]) * AW'(active[n]);
            for (int n = NP; n < N2; n++)
               s[n] <= '0;
         end
      end else begin : g_add
         always_ff @(posedge clk) begin
            for (int n = 0; n < (N2 >> l); n++)
               s[n] <= g_lvl[l-1].s[2*n] + g_lvl[l-1].s[2*n+1];
         end
      end
   end

   assign sum = g_lvl[AL].s[0];

   if (SHIFT > 0) begin : g_round
      assign rounded = (XW'(sum) + (XW'(1) << (SHIFT - 1))) >> SHIFT;
   end else begin : g_noround
      assign rounded = XW'(sum);
   end

   assign clip = (rounded > OMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
         sat  <= 1'b0;
      end else if (vld[LAT-1]) begin
         dout <= clip ? {OW{1'b1}} : rounded[OW-1:0];
         sat  <= clip;
      end
   end

endmodule

// File: tb/tb_sym_conv2d_param.sv
// Self-checking bench for sym_conv2d_param: directed and random windows, scoreboard against
// a direct KxK convolution model, commit timing and mid-stream reset.
module tb_sym_conv2d_param;

   localparam int K    = 11;
   localparam int DW   = 8;
   localparam int CW   = 8;
   localparam int OW   = 18;
   localparam int HK   = (K + 1) / 2;
   localparam int NP   = HK * HK;
   localparam int AB   = $clog2(NP);
   localparam int LAT  = 3 + $clog2(NP) + 1;
   localparam longint OMAX = (64'd1 << OW) - 1;

   typedef logic [K*K*DW-1:0] win_t;
   typedef struct {
      longint raw;
      int     cyc;
   } item_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          coef_we = 1'b0;
   logic          coef_commit = 1'b0;
   win_t          din = '0;
   logic [AB-1:0] coef_addr = '0;
   logic [CW-1:0] coef_wdata = '0;
   logic          in_ready0, out_valid0, sat0;
   logic          in_ready4, out_valid4, sat4;
   logic [OW-1:0] dout0, dout4;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   item_t       sb[$];
   int unsigned shadow_m [NP];
   int unsigned active_m [NP];
   bit          prev_ready = 1'b1;
   bit          wr_pend = 1'b0;
   int          wr_addr = 0;
   int          wr_data = 0;

   sym_conv2d_param #(.K(K), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_commit(coef_commit), .dout(dout0), .out_valid(out_valid0), .sat(sat0)
   );

   sym_conv2d_param #(.K(K), .DW(DW), .CW(CW), .OW(OW), .SHIFT(4)) dut_s4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_commit(coef_commit), .dout(dout4), .out_valid(out_valid4), .sat(sat4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Direct KxK sum; symmetry is expressed only through the folded coefficient index.
   function automatic longint ref_sum(input win_t w);
      longint acc = 0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            int fr = (r < K-1-r) ? r : K-1-r;
            int fc = (c < K-1-c) ? c : K-1-c;
            acc += longint'(w[(r*K + c)*DW +: DW]) * longint'(active_m[fr*HK + fc]);
         end
      end
      return acc;
   endfunction

   function automatic longint rnd(input longint raw, input int sh);
      if (sh > 0) return (raw + (longint'(1) << (sh - 1))) >> sh;
      return raw;
   endfunction

   function automatic win_t fill(input int v);
      win_t w;
      for (int n = 0; n < K*K; n++) w[n*DW +: DW] = DW'(v);
      return w;
   endfunction

   function automatic win_t impulse(input int r, input int c, input int v);
      win_t w = '0;
      w[(r*K + c)*DW +: DW] = DW'(v);
      return w;
   endfunction

   function automatic win_t rand_win();
      win_t w;
      for (int n = 0; n < K*K; n++) w[n*DW +: DW] = DW'($urandom_range(255, 0));
      return w;
   endfunction

   // Output monitor: out_valid must appear exactly LAT cycles after each accepted window.
   always @(negedge clk) begin
      bit     due;
      item_t  it;
      longint e0, e4;
      due = (sb.size() > 0) && (sb[0].cyc + LAT == cyc);
      check("out_valid", out_valid0, due);
      check("out_valid_s4", out_valid4, due);
      if (due) begin
         it = sb.pop_front();
         e0 = rnd(it.raw, 0);
         e4 = rnd(it.raw, 4);
         check("dout", dout0, (e0 > OMAX) ? OMAX : e0);
         check("sat", sat0, e0 > OMAX);
         check("dout_s4", dout4, (e4 > OMAX) ? OMAX : e4);
         check("sat_s4", sat4, e4 > OMAX);
      end
   end

   // One clock of stimulus, entered and left on a falling edge.
   task automatic step(input bit v, input win_t w, input bit we = 1'b0, input int addr = 0,
                       input int data = 0, input bit commit = 1'b0);
      if (in_ready0 && !prev_ready) active_m = shadow_m;
      prev_ready = in_ready0;
      if (wr_pend && wr_addr < NP) shadow_m[wr_addr] = wr_data;
      wr_pend     = we;
      wr_addr     = addr;
      wr_data     = data;
      in_valid    = v;
      din         = w;
      coef_we     = we;
      coef_addr   = addr[AB-1:0];
      coef_wdata  = data[CW-1:0];
      coef_commit = commit;
      if (v && in_ready0) sb.push_back('{ref_sum(w), cyc});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic load_all(input int v);
      for (int n = 0; n < NP; n++) step(1'b0, '0, 1'b1, n, v);
   endtask

   task automatic commit_wait();
      int n = 0;
      step(1'b0, '0, 1'b0, 0, 0, 1'b1);
      while (!in_ready0 && n < 64) begin
         step(1'b0, '0);
         n++;
      end
      check("commit_timeout", in_ready0, 1'b1);
      step(1'b0, '0);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      in_valid    = 1'b0;
      coef_we     = 1'b0;
      coef_commit = 1'b0;
      sb.delete();
      for (int n = 0; n < NP; n++) begin
         shadow_m[n] = 0;
         active_m[n] = 0;
      end
      prev_ready = 1'b1;
      wr_pend    = 1'b0;
      #2;
      check("rst_out_valid", out_valid0, 1'b0);
      check("rst_dout", dout0, 0);
      check("rst_dout_s4", dout4, 0);
      check("rst_sat", sat0, 1'b0);
      check("rst_in_ready", in_ready0, 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int n = 0; n < NP; n++) begin
         shadow_m[n] = 0;
         active_m[n] = 0;
      end
      @(negedge clk);
      check("init_out_valid", out_valid0, 1'b0);
      check("init_dout", dout0, 0);
      check("init_sat", sat0, 1'b0);
      check("init_in_ready", in_ready0, 1'b1);
      #2 rst = 1'b0;
      @(negedge clk);

      // All-ones coefficients and windows: 121 every cycle.
      load_all(1);
      commit_wait();
      for (int i = 0; i < 20; i++) step(1'b1, fill(1));
      idle(LAT + 2);

      // Impulse at centre, (0,0) and (10,10): fold symmetry.
      load_all(0);
      step(1'b0, '0, 1'b1, NP - 1, 3);
      commit_wait();
      step(1'b1, impulse(HK - 1, HK - 1, 200));
      idle(2);
      step(1'b0, '0, 1'b1, NP - 1, 0);
      step(1'b0, '0, 1'b1, 0, 3);
      commit_wait();
      step(1'b1, impulse(0, 0, 200));
      step(1'b1, impulse(K - 1, K - 1, 200));
      idle(LAT + 2);

      // Full-scale window and coefficients: saturation.
      load_all(255);
      commit_wait();
      for (int i = 0; i < 3; i++) step(1'b1, fill(255));
      idle(LAT + 2);

      // Rounding boundary on the SHIFT=4 instance: 24 -> 2, 23 -> 1.
      load_all(0);
      step(1'b0, '0, 1'b1, NP - 1, 1);
      commit_wait();
      step(1'b1, impulse(HK - 1, HK - 1, 24));
      step(1'b1, impulse(HK - 1, HK - 1, 23));
      step(1'b1, impulse(HK - 1, HK - 1, 8));
      step(1'b1, impulse(HK - 1, HK - 1, 7));
      idle(LAT + 2);

      // Random coefficients, then a new set written into shadow while streaming.
      for (int n = 0; n < NP; n++) step(1'b0, '0, 1'b1, n, $urandom_range(15, 0));
      commit_wait();
      for (int n = 0; n < NP; n++)
         step(1'b1, rand_win(), 1'b1, n, (n == NP - 1) ? 5 : $urandom_range(15, 0));
      step(1'b1, rand_win(), 1'b1, 63, 77);
      step(1'b1, rand_win(), 1'b1, 40, 99);
      step(1'b1, rand_win(), 1'b0, 0, 0, 1'b1);
      for (int k = 1; k <= LAT + 1; k++) begin
         check("commit_ready_low", in_ready0, 1'b0);
         step(1'b1, rand_win(), k == LAT + 1, NP - 1, 9);
      end
      check("commit_ready_back", in_ready0, 1'b1);
      step(1'b1, impulse(HK - 1, HK - 1, 200));
      for (int i = 0; i < 12; i++) step(1'b1, rand_win());
      commit_wait();
      step(1'b1, impulse(HK - 1, HK - 1, 200));
      for (int i = 0; i < 6; i++) step(1'b1, rand_win());
      idle(LAT + 2);

      // Reset in the middle of a stream with a commit pending.
      step(1'b1, rand_win());
      step(1'b1, rand_win());
      step(1'b1, rand_win(), 1'b0, 0, 0, 1'b1);
      step(1'b1, rand_win());
      do_reset();
      check("post_rst_in_ready", in_ready0, 1'b1);
      check("post_rst_dout", dout0, 0);
      check("post_rst_out_valid", out_valid0, 1'b0);
      idle(LAT + 4);
      step(1'b1, fill(1));
      idle(LAT + 2);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
